// File: rtl/tour_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tour_pkg
// Description : Shared opcodes, headings, response codes, FSM state encoding
//               and a lowest-set-bit helper for the knight-tour command
//               sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package tour_pkg;

   // Command opcodes (cmd[15:12])
   localparam logic [3:0] c_OP_MOVE         = 4'h2;
   localparam logic [3:0] c_OP_MOVE_FANFARE = 4'h3;

   // Headings (cmd[11:4])
   localparam logic [7:0] c_HEAD_N = 8'h00;
   localparam logic [7:0] c_HEAD_W = 8'h3F;
   localparam logic [7:0] c_HEAD_S = 8'h7F;
   localparam logic [7:0] c_HEAD_E = 8'hBF;

   // Response bytes
   localparam logic [7:0] c_RESP_ACK  = 8'hA5;
   localparam logic [7:0] c_RESP_BUSY = 8'h5A;

   // Index of the final move of a 24-move tour
   localparam logic [4:0] c_LAST_MV = 5'd23;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      VERT      = 3'd1,
      VERT_WAIT = 3'd2,
      HORZ      = 3'd3,
      HORZ_WAIT = 3'd4
   } state_t;

   // Index of the lowest set bit; an all-zero vector maps to bit 0.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tour_move_dec.sv
`default_nettype none
// ============================================================================
// Module      : tour_move_dec
// Description : Decodes a one-hot knight move into a vertical leg and a
//               horizontal leg (heading + square count each).
// Ports       : i_move       in  8  one-hot move (lowest set bit wins)
//               o_vert_head  out 8  heading of the vertical leg
//               o_vert_sq    out 4  squares of the vertical leg
//               o_horz_head  out 8  heading of the horizontal leg
//               o_horz_sq    out 4  squares of the horizontal leg
// Revision    : 1.0  initial release
// ============================================================================
module tour_move_dec
   import tour_pkg::*;
(
   input  logic [7:0] i_move,
   output logic [7:0] o_vert_head,
   output logic [3:0] o_vert_sq,
   output logic [7:0] o_horz_head,
   output logic [3:0] o_horz_sq
);

   logic [2:0] w_sel;

   assign w_sel = lowest_set(i_move);

   always_comb begin
      o_vert_head = c_HEAD_N;
      o_vert_sq   = 4'd2;
      o_horz_head = c_HEAD_E;
      o_horz_sq   = 4'd1;
      case (w_sel)
         3'd0: begin o_vert_head = c_HEAD_N; o_vert_sq = 4'd2; o_horz_head = c_HEAD_E; o_horz_sq = 4'd1; end
         3'd1: begin o_vert_head = c_HEAD_N; o_vert_sq = 4'd2; o_horz_head = c_HEAD_W; o_horz_sq = 4'd1; end
         3'd2: begin o_vert_head = c_HEAD_N; o_vert_sq = 4'd1; o_horz_head = c_HEAD_W; o_horz_sq = 4'd2; end
         3'd3: begin o_vert_head = c_HEAD_S; o_vert_sq = 4'd1; o_horz_head = c_HEAD_W; o_horz_sq = 4'd2; end
         3'd4: begin o_vert_head = c_HEAD_S; o_vert_sq = 4'd2; o_horz_head = c_HEAD_W; o_horz_sq = 4'd1; end
         3'd5: begin o_vert_head = c_HEAD_S; o_vert_sq = 4'd2; o_horz_head = c_HEAD_E; o_horz_sq = 4'd1; end
         3'd6: begin o_vert_head = c_HEAD_S; o_vert_sq = 4'd1; o_horz_head = c_HEAD_E; o_horz_sq = 4'd2; end
         default: begin o_vert_head = c_HEAD_N; o_vert_sq = 4'd1; o_horz_head = c_HEAD_E; o_horz_sq = 4'd2; end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tour_cmd_seq
// Description : Sequences a stored 24-move knight tour into pairs of
//               MOVE / MOVE_FANFARE commands, and otherwise passes UART
//               commands straight through to the command processor.
// Ports       : clk, rst          clock / synchronous active-high reset
//               start_tour  in 1  pulse, begins a tour (IDLE only)
//               move        in 8  move memory data at mv_indx
//               mv_indx     out 5 current move index 0..23
//               cmd_UART    in 16 / cmd_rdy_UART in 1  UART command path
//               clr_cmd_rdy in 1  processor accepted cmd
//               send_resp   in 1  processor finished cmd
//               cmd         out 16 / cmd_rdy out 1  muxed command
//               resp        out 8 response byte to UART
// Revision    : 1.0  initial release
// ============================================================================
module tour_cmd_seq
   import tour_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic [7:0]  resp
);

   state_t     r_state;
   logic [4:0] r_mv_indx;
   logic [7:0] r_move;

   state_t     w_state_nxt;
   logic [4:0] w_mv_indx_nxt;
   logic [7:0] w_move_nxt;
   logic [7:0] w_move_sel;
   logic [7:0] w_vert_head;
   logic [3:0] w_vert_sq;
   logic [7:0] w_horz_head;
   logic [3:0] w_horz_sq;

   // Live move data is used while in VERT; from then on the captured copy
   // keeps both command halves stable until the move is finished.
   assign w_move_sel = (r_state == VERT) ? move : r_move;

   tour_move_dec u_move_dec (
      .i_move      (w_move_sel),
      .o_vert_head (w_vert_head),
      .o_vert_sq   (w_vert_sq),
      .o_horz_head (w_horz_head),
      .o_horz_sq   (w_horz_sq)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mv_indx <= 5'd0;
         r_move    <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_mv_indx <= w_mv_indx_nxt;
         r_move    <= w_move_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_mv_indx_nxt = r_mv_indx;
      w_move_nxt    = r_move;
      case (r_state)
         IDLE: begin
            if (start_tour) begin
               w_state_nxt   = VERT;
               w_mv_indx_nxt = 5'd0;
            end
         end
         VERT: begin
            w_move_nxt = move;
            // clr_cmd_rdy alone decides the step; a coincident send_resp
            // is not allowed to skip VERT_WAIT.
            if (clr_cmd_rdy) w_state_nxt = VERT_WAIT;
         end
         VERT_WAIT: begin
            if (send_resp) w_state_nxt = HORZ;
         end
         HORZ: begin
            if (clr_cmd_rdy) w_state_nxt = HORZ_WAIT;
         end
         HORZ_WAIT: begin
            if (send_resp) begin
               if (r_mv_indx >= c_LAST_MV) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt   = VERT;
                  w_mv_indx_nxt = r_mv_indx + 5'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
      resp    = c_RESP_BUSY;
      case (r_state)
         VERT: begin
            cmd     = {c_OP_MOVE, w_vert_head, w_vert_sq};
            cmd_rdy = 1'b1;
         end
         VERT_WAIT: begin
            cmd     = {c_OP_MOVE, w_vert_head, w_vert_sq};
            cmd_rdy = 1'b0;
         end
         HORZ: begin
            cmd     = {c_OP_MOVE_FANFARE, w_horz_head, w_horz_sq};
            cmd_rdy = 1'b1;
         end
         HORZ_WAIT: begin
            cmd     = {c_OP_MOVE_FANFARE, w_horz_head, w_horz_sq};
            cmd_rdy = 1'b0;
            if (r_mv_indx == c_LAST_MV) resp = c_RESP_ACK;
         end
         default: resp = c_RESP_ACK;
      endcase
   end

   assign mv_indx = r_mv_indx;

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tour_cmd_seq
// Description : Self-checking bench for tour_cmd_seq: decode vector table,
//               UART pass-through, full tour, mid-tour reset and overlap
//               corner cases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tour_cmd_seq;

   typedef struct {
      logic [7:0]  mv;
      logic [15:0] vcmd;
      logic [15:0] hcmd;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic [7:0]  resp;

   logic        use_mem;
   logic [7:0]  move_drv;
   logic [7:0]  mem [24];
   vec_t        vec [12];

   int n_checks = 0;
   int n_pass   = 0;

   tour_cmd_seq dut (
      .clk          (clk),
      .rst          (rst),
      .start_tour   (start_tour),
      .move         (move),
      .mv_indx      (mv_indx),
      .cmd_UART     (cmd_UART),
      .cmd_rdy_UART (cmd_rdy_UART),
      .clr_cmd_rdy  (clr_cmd_rdy),
      .send_resp    (send_resp),
      .cmd          (cmd),
      .cmd_rdy      (cmd_rdy),
      .resp         (resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      move = move_drv;
      if (use_mem) begin
         move = 8'h00;
         if (mv_indx < 5'd24) move = mem[mv_indx];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Ideal processor handling command number c (0..47) of a tour.
   task automatic proc_cmd(input int c);
      int t;
      logic [15:0] exp;
      t = 0;
      while (!cmd_rdy && t < 50) begin
         tick();
         t++;
      end
      check("tour_rdy_wait", {15'd0, cmd_rdy}, 16'd1);
      exp = (c % 2 == 0) ? vec[(c / 2) % 8].vcmd : vec[(c / 2) % 8].hcmd;
      check("tour_cmd", cmd, exp);
      check("tour_idx", {11'd0, mv_indx}, 16'(c / 2));
      repeat (2) tick();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      check("tour_rdy_low", {15'd0, cmd_rdy}, 16'd0);
      repeat (9) tick();
      send_resp = 1'b1;
      check("tour_resp", {8'd0, resp}, (c == 47) ? 16'h00A5 : 16'h005A);
      tick();
      send_resp = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
      clr_cmd_rdy = 1'b0; send_resp = 1'b0; use_mem = 1'b0; move_drv = 8'h00;

      // Entries 0..7 are the one-hot moves in bit order.
      vec[0]  = '{8'h01, 16'h2002, 16'h3BF1};
      vec[1]  = '{8'h02, 16'h2002, 16'h33F1};
      vec[2]  = '{8'h04, 16'h2001, 16'h33F2};
      vec[3]  = '{8'h08, 16'h27F1, 16'h33F2};
      vec[4]  = '{8'h10, 16'h27F2, 16'h33F1};
      vec[5]  = '{8'h20, 16'h27F2, 16'h3BF1};
      vec[6]  = '{8'h40, 16'h27F1, 16'h3BF2};
      vec[7]  = '{8'h80, 16'h2001, 16'h3BF2};
      vec[8]  = '{8'h48, 16'h27F1, 16'h33F2};
      vec[9]  = '{8'h00, 16'h2002, 16'h3BF1};
      vec[10] = '{8'hC0, 16'h27F1, 16'h3BF2};
      vec[11] = '{8'hFF, 16'h2002, 16'h3BF1};
      for (int i = 0; i < 24; i++) mem[i] = 8'h01 << (i % 8);

      // Reset state and UART pass-through
      do_reset();
      cmd_UART = 16'h4022; cmd_rdy_UART = 1'b1;
      #1;
      check("rst_cmd", cmd, 16'h4022);
      check("rst_rdy", {15'd0, cmd_rdy}, 16'd1);
      check("rst_resp", {8'd0, resp}, 16'h00A5);
      check("rst_idx", {11'd0, mv_indx}, 16'd0);
      // clr/send ignored in UART mode
      clr_cmd_rdy = 1'b1; send_resp = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0;
      #1;
      check("uart_cmd2", cmd, 16'h1234);
      check("uart_rdy2", {15'd0, cmd_rdy}, 16'd0);

      // Decode table: one move each
      for (int i = 0; i < 12; i++) begin
         do_reset();
         move_drv = vec[i].mv;
         cmd_rdy_UART = 1'b1;
         start_tour = 1'b1;
         tick();
         start_tour = 1'b0;
         check("vec_vert_cmd", cmd, vec[i].vcmd);
         check("vec_vert_rdy", {15'd0, cmd_rdy}, 16'd1);
         clr_cmd_rdy = 1'b1;
         tick();
         clr_cmd_rdy = 1'b0;
         move_drv = ~vec[i].mv;
         #1;
         check("vec_vert_hold", cmd, vec[i].vcmd);
         check("vec_vwait_rdy", {15'd0, cmd_rdy}, 16'd0);
         send_resp = 1'b1;
         tick();
         send_resp = 1'b0;
         check("vec_horz_cmd", cmd, vec[i].hcmd);
         check("vec_horz_rdy", {15'd0, cmd_rdy}, 16'd1);
         clr_cmd_rdy = 1'b1;
         tick();
         clr_cmd_rdy = 1'b0;
         check("vec_horz_hold", cmd, vec[i].hcmd);
         check("vec_hwait_resp", {8'd0, resp}, 16'h005A);
      end
      cmd_rdy_UART = 1'b0;

      // Full tour with ideal processor
      do_reset();
      use_mem = 1'b1;
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      for (int c = 0; c < 48; c++) proc_cmd(c);
      cmd_UART = 16'hBEEF;
      #1;
      check("tour_end_cmd", cmd, 16'hBEEF);
      check("tour_end_resp", {8'd0, resp}, 16'h00A5);
      check("tour_end_idx", {11'd0, mv_indx}, 16'd23);
      repeat (5) tick();
      check("tour_no_extra", {15'd0, cmd_rdy}, 16'd0);

      // Reset mid-tour at mv_indx 10 in HORZ_WAIT
      do_reset();
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      for (int c = 0; c < 21; c++) proc_cmd(c);
      check("mid_horz_cmd", cmd, vec[2].hcmd);
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      check("mid_idx10", {11'd0, mv_indx}, 16'd10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cmd_UART = 16'h7777; cmd_rdy_UART = 1'b1;
      #1;
      check("mid_rst_idx", {11'd0, mv_indx}, 16'd0);
      check("mid_rst_cmd", cmd, 16'h7777);
      check("mid_rst_rdy", {15'd0, cmd_rdy}, 16'd1);
      check("mid_rst_resp", {8'd0, resp}, 16'h00A5);

      // start_tour mid-tour and clr+send overlap in VERT
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      tick();
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      check("ovl_vert_rdy", {15'd0, cmd_rdy}, 16'd1);
      check("ovl_vert_idx", {11'd0, mv_indx}, 16'd0);
      clr_cmd_rdy = 1'b1; send_resp = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      check("ovl_vwait_cmd", cmd, 16'h2002);
      check("ovl_vwait_rdy", {15'd0, cmd_rdy}, 16'd0);
      tick();
      check("ovl_vwait_stay", cmd, 16'h2002);
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      check("ovl_horz_cmd", cmd, 16'h3BF1);
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      start_tour = 1'b1; send_resp = 1'b1;
      tick();
      start_tour = 1'b0; send_resp = 1'b0;
      check("ovl_next_idx", {11'd0, mv_indx}, 16'd1);
      check("ovl_next_cmd", cmd, 16'h2002);
      check("ovl_next_rdy", {15'd0, cmd_rdy}, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tour_cmd_seq.md
TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (all logic on posedge).
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have ports: start_tour  in  1  one-cycle pulse; starts sequencing a stored 24-move tour.
REQ-004 SHALL have ports: move  in  8  one-hot knight move read at address mv_indx (move memory, combinational read).
REQ-005 SHALL have ports: mv_indx  out  5  current move index, 0..23.
REQ-006 SHALL have ports: cmd_UART  in  16 / cmd_rdy_UART  in  1  command and valid flag from the UART wrapper.
REQ-007 SHALL have ports: clr_cmd_rdy  in  1  command processor accepted the current cmd.
REQ-008 SHALL have ports: send_resp  in  1  command processor finished the current cmd.
REQ-009 SHALL have ports: cmd  out  16 / cmd_rdy  out  1  muxed command and valid flag to the command processor.
REQ-010 SHALL have ports: resp  out  8  response byte to the UART wrapper.

Function
REQ-011 Command format SHALL be [15:12] opcode, [11:4] heading, [3:0] squares; MOVE=4'h2, MOVE_FANFARE=4'h3.
REQ-012 Headings SHALL be N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
REQ-013 Each move SHALL be issued as two commands: vertical first (opcode MOVE), then horizontal (opcode MOVE_FANFARE).
REQ-014 Move decode (bit: vertical, horizontal) SHALL be: b0 N2,E1; b1 N2,W1; b2 N1,W2; b3 S1,W2; b4 S2,W1; b5 S2,E1; b6 S1,E2; b7 N1,E2.
REQ-015 A non-one-hot move SHALL decode by its lowest set bit; all-zero SHALL decode as b0.
REQ-016 The FSM SHALL have states IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT.
REQ-017 IDLE->VERT on start_tour, with mv_indx cleared to 0; cmd_rdy SHALL be high in the next cycle.
REQ-018 VERT->VERT_WAIT on clr_cmd_rdy; cmd_rdy SHALL be low in the following cycle.
REQ-019 VERT_WAIT->HORZ on send_resp.
REQ-020 HORZ->HORZ_WAIT on clr_cmd_rdy.
REQ-021 HORZ_WAIT on send_resp: if mv_indx==23 ->IDLE; else mv_indx+1 and ->VERT.
REQ-022 cmd_rdy SHALL be high exactly in VERT and HORZ while in tour mode.
REQ-023 cmd SHALL hold constant from VERT entry until VERT_WAIT exit, and likewise for HORZ/HORZ_WAIT.
REQ-024 Tour mode SHALL be every state other than IDLE; IDLE is UART mode.
REQ-025 In UART mode, cmd=cmd_UART and cmd_rdy=cmd_rdy_UART combinationally; clr_cmd_rdy and send_resp are ignored by the FSM.
REQ-026 resp SHALL be 8'hA5 in UART mode and in HORZ_WAIT with mv_indx==23; otherwise 8'h5A.
REQ-027 start_tour SHALL be ignored outside IDLE.
REQ-028 cmd_rdy_UART SHALL be ignored (not forwarded) in tour mode.
REQ-029 clr_cmd_rdy and send_resp asserted in the same cycle SHALL act only as clr_cmd_rdy (one state step per cycle).
REQ-030 mv_indx SHALL never exceed 23.

Reset
REQ-031 rst SHALL force IDLE and mv_indx=0 on the next edge, including mid-tour.
REQ-032 After reset, cmd_rdy SHALL equal cmd_rdy_UART, cmd SHALL equal cmd_UART, and resp SHALL be 8'hA5.

Structure
REQ-033 Opcodes, headings and the state enum SHALL live in shared package tour_pkg.
REQ-034 Move decode SHALL be sub-module tour_move_dec (one-hot -> vertical/horizontal heading and squares).
REQ-035 All registers SHALL be in a single clocked process; the output mux SHALL be combinational.

Verification
REQ-036 Reset, then cmd_UART=16'h4022, cmd_rdy_UART=1 -> cmd=16'h4022, cmd_rdy=1, resp=8'hA5.
REQ-037 start_tour with move=8'h01 -> next cycle cmd=16'h2002, cmd_rdy=1; after clr_cmd_rdy then send_resp -> cmd=16'h3BF1.
REQ-038 Full tour with an ideal processor model (clr after 2 cycles, send_resp after 10) -> exactly 48 commands issued; resp=8'h5A on the first 47 send_resp and 8'hA5 on the 48th; FSM returns to IDLE.
REQ-039 move=8'h48 (b3,b6 set) -> decodes as b3: cmd 16'h27F1, then 16'h33F2.
REQ-040 rst at mv_indx=10 in HORZ_WAIT -> next cycle IDLE, mv_indx=0, cmd tracks cmd_UART.
REQ-041 start_tour pulsed mid-tour, and clr_cmd_rdy+send_resp asserted together in VERT -> no index restart, single step to VERT_WAIT.
